// File: rtl/mem_writeback.sv
// mem_writeback: memory access over req/ack, then register-file and PC commit for one Execute result
module mem_writeback #(
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [15:0] PC_INC      = 16'd1
) (
    input  logic        T1,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] IR,
    input  logic [7:0]  ALUOUT,
    input  logic [7:0]  valA,
    input  logic [15:0] Addr,
    input  logic [15:0] PC,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        pc_we,
    output logic [15:0] pc_next,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

    localparam logic [4:0] OP_LOAD  = 5'b01000;
    localparam logic [4:0] OP_STORE = 5'b01001;
    localparam logic [4:0] OP_JMP   = 5'b10000;
    localparam logic [4:0] OP_JZ    = 5'b10001;

    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [2:0]  rd_q, rd_d;
    logic [7:0]  alu_q, alu_d;
    logic [7:0]  vala_q, vala_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        rf_we_q, rf_we_d;
    logic [7:0]  rf_wdata_q, rf_wdata_d;
    logic        pc_we_q, pc_we_d;
    logic [15:0] pc_next_q, pc_next_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [4:0]  in_op;
    logic        in_mem;
    logic        timeout;

    function automatic logic [15:0] next_pc(input logic [4:0] op, input logic [7:0] a,
                                            input logic [15:0] tgt, input logic [15:0] pc);
        next_pc = (op == OP_JMP || (op == OP_JZ && a == 8'h00)) ? tgt : pc + PC_INC;
    endfunction

    assign in_op     = IR[15:11];
    assign in_mem    = (in_op == OP_LOAD) || (in_op == OP_STORE);
    assign timeout   = (cnt_q + 8'd1) == 8'(MEM_TIMEOUT);
    assign in_ready  = in_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = {8'h00, alu_q};
    assign mem_wdata = vala_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = rf_wdata_q;
    assign pc_we     = pc_we_q;
    assign pc_next   = pc_next_q;
    assign done      = done_q;
    assign err       = err_q;

    // next-state and registered-output computation; WB strobes are prepared on the edge entering WB
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        vala_d     = vala_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        in_ready_d = in_ready_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        rf_we_d    = 1'b0;
        rf_wdata_d = rf_wdata_q;
        pc_we_d    = 1'b0;
        pc_next_d  = pc_next_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d       = in_op;
                rd_d       = IR[10:8];
                alu_d      = ALUOUT;
                vala_d     = valA;
                addr_d     = Addr;
                pc_d       = PC;
                cnt_d      = 8'd0;
                in_ready_d = 1'b0;
                state_d    = in_mem ? MEM : WB;
                mem_req_d  = in_mem;
                mem_we_d   = in_op == OP_STORE;
                done_d     = !in_mem;
                pc_we_d    = !in_mem;
                rf_we_d    = !in_mem && !in_op[4] && !in_op[3];
                rf_wdata_d = ALUOUT;
                pc_next_d  = next_pc(in_op, valA, Addr, PC);
            end
            MEM: if (mem_ack || timeout) begin
                state_d    = WB;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                cnt_d      = 8'd0;
                done_d     = 1'b1;
                pc_we_d    = 1'b1;
                rf_we_d    = mem_ack && op_q == OP_LOAD;
                rf_wdata_d = mem_ack ? mem_rdata : rf_wdata_q;
                err_d      = err_q || !mem_ack;
                pc_next_d  = next_pc(op_q, vala_q, addr_q, pc_q);
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // state, capture and output registers with synchronous reset
    always_ff @(posedge T1) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            vala_q     <= '0;
            addr_q     <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= '0;
            pc_we_q    <= 1'b0;
            pc_next_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            vala_q     <= vala_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
            pc_we_q    <= pc_we_d;
            pc_next_q  <= pc_next_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Back end of the Execute stage: consumes ALUOUT, valA, Addr and IR for one instruction.
- Performs any data-memory access over a req/ack handshake.
- Then commits the result: register-file write and PC update.
- Sits between Execute and the register file / PC. It is the consumer of everything Execute produces.

Parameters:
- MEM_TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before aborting (1..255).
- PC_INC, 1, increment applied to PC for fall-through instructions.

Ports:
- T1  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  Execute presents a completed instruction
- in_ready  out  1  block can accept an instruction (high only in IDLE)
- IR  in  16  instruction: [15:11] opcode, [10:8] rd, [7:5] rs
- ALUOUT  in  8  Execute result, or memory address low byte for LOAD/STORE
- valA  in  8  store data; zero test operand for JZ
- Addr  in  16  branch target
- PC  in  16  PC of this instruction
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read; valid while mem_req
- mem_addr  out  16  {8'h00, ALUOUT_captured}
- mem_wdata  out  8  captured valA
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse
- rf_we  out  1  register write strobe (1 cycle)
- rf_waddr  out  3  destination register
- rf_wdata  out  8  write data
- pc_we  out  1  PC load strobe (1 cycle)
- pc_next  out  16  next PC value
- done  out  1  instruction retired (1 cycle)
- err  out  1  sticky memory-timeout flag

Behaviour:
- Reset values: all outputs 0, except in_ready=1. FSM goes to IDLE, timeout counter 0, err 0. All capture registers are 0.
- Reset mid-operation: rst wins on the same edge from any state. mem_req drops the next cycle. A late mem_ack after reset is ignored.
- Opcode classes:
  - 00000-00111: ALU
  - 01000: LOAD
  - 01001: STORE
  - 10000: JMP
  - 10001: JZ
  - any other opcode: NOP
- States: IDLE, MEM, WB.
- IDLE:
  - in_ready=1.
  - When in_valid=1: capture IR, ALUOUT, valA, Addr and PC, then drop in_ready.
  - LOAD or STORE goes to MEM. Every other class goes to WB.
- MEM:
  - mem_req=1, with mem_we=1 for STORE. mem_addr and mem_wdata are stable throughout.
  - The counter increments every cycle while mem_ack=0.
  - mem_ack=1: latch mem_rdata for LOAD, clear the counter, go to WB.
  - Counter reaches MEM_TIMEOUT with no ack: set err, mark the instruction aborted, go to WB.
  - If ack arrives on the same cycle the counter reaches MEM_TIMEOUT, the ack wins: no err.
- WB (exactly one cycle, then IDLE):
  - done=1 and pc_we=1.
  - ALU: rf_we=1, rf_wdata=ALUOUT.
  - LOAD (not aborted): rf_we=1, rf_wdata=latched mem_rdata.
  - STORE, JMP, JZ, NOP, or any aborted access: rf_we=0.
  - rf_waddr=IR[10:8].
  - pc_next:
    - JMP: Addr.
    - JZ: Addr if valA==8'h00, else PC+PC_INC.
    - All others: PC+PC_INC, mod 2^16 (16'hFFFF wraps to 16'h0000).
- Latency:
  - Non-memory instruction: accepted at edge N, WB strobes high in cycle N+1, in_ready high again in cycle N+2.
  - Memory instruction: 2 + (cycles until ack).
- in_valid outside IDLE is ignored; no buffering. The producer must hold in_valid until it sees in_ready.
- mem_ack outside MEM is ignored.
- err stays set until rst. Later instructions still execute normally.
- ALUOUT is 8-bit and unsigned; no extension is applied to rf_wdata.

Test Plan:
- ALU writeback: IR=16'b00000_000_001_00000, ALUOUT=8'h0F, PC=16'h0001, in_valid 1 cycle -> next cycle rf_we=1, rf_waddr=0, rf_wdata=8'h0F, pc_we=1, pc_next=16'h0002, done=1; in_ready back high the cycle after.
- LOAD with ack after 3 cycles: IR opcode 01000, rd=3, ALUOUT=8'h20, mem_rdata=8'hA5 -> mem_req held 3 cycles, mem_addr=16'h0020, mem_we=0; WB: rf_waddr=3, rf_wdata=8'hA5, pc_next=PC+1.
- STORE, then timeout: opcode 01001, valA=8'h5A, ALUOUT=8'h10, mem_ack never -> mem_req high for 15 cycles, mem_wdata=8'h5A, mem_we=1; err=1, WB with rf_we=0, pc_next=PC+1. A following ALU instruction still retires with err still 1.
- Branches:
  - JZ with valA=0, Addr=16'h0040 -> pc_next=16'h0040, rf_we=0.
  - JZ with valA=8'h01, PC=16'hFFFF -> pc_next=16'h0000.
  - JMP Addr=16'h1234 -> pc_next=16'h1234.
- Reset mid-MEM: assert rst on the second cycle of a LOAD's mem_req -> next cycle mem_req=0, in_ready=1, no done/rf_we. A mem_ack pulse one cycle later causes nothing.
- Ack on the timeout cycle: mem_ack arrives exactly on cycle 15 -> err stays 0, LOAD writes the returned data.
